// File: rtl/bcd_rtc.sv
// BCD real-time clock: prescaled second tick, 24h time with carry chain, 12h view and guarded load.
// Optional alarm comparator is built only when BCD_RTC_ALARM_EN is defined.
module bcd_rtc #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int          DIV_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       set,
  input  logic [7:0] s_hh,
  input  logic [7:0] s_mm,
  input  logic [7:0] s_ss,
`ifdef BCD_RTC_ALARM_EN
  input  logic       al_en,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  output logic       alarm,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] hh12,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_tick,
  output logic       set_err
);

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] presc_reg;
  logic [7:0]       hh_reg, mm_reg, ss_reg;
  logic [7:0]       hh_next, mm_next, ss_next;
  logic [7:0]       hh_inc, mm_inc, ss_inc;
  logic             sec_tick_reg, min_tick_reg, day_tick_reg, set_err_reg;
  logic             tick, sec_carry, min_carry, day_carry;
  logic [23:0]      load_bus;
  logic [5:0]       digit_ok;
  logic             range_ok, load_ok;

  // Every loaded nibble must be a decimal digit before the field ranges mean anything.
  assign load_bus = {s_hh, s_mm, s_ss};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_ok[gi] = (load_bus[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign range_ok = (s_ss[7:4] <= 4'd5) && (s_mm[7:4] <= 4'd5) &&
                    ((s_hh[7:4] < 4'd2) || ((s_hh[7:4] == 4'd2) && (s_hh[3:0] <= 4'd3)));
  assign load_ok  = (&digit_ok) && range_ok;

  // A load request always wins over the second tick.
  assign tick      = ena && !set && (presc_reg == PRESC_MAX);
  assign sec_carry = tick && (ss_reg == 8'h59);
  assign min_carry = sec_carry && (mm_reg == 8'h59);
  assign day_carry = min_carry && (hh_reg == 8'h23);

  always_comb begin
    ss_inc = 8'h00;
    if (ss_reg != 8'h59) begin
      if (ss_reg[3:0] == 4'd9) ss_inc = {ss_reg[7:4] + 4'd1, 4'd0};
      else                     ss_inc = {ss_reg[7:4], ss_reg[3:0] + 4'd1};
    end
  end

  always_comb begin
    mm_inc = 8'h00;
    if (mm_reg != 8'h59) begin
      if (mm_reg[3:0] == 4'd9) mm_inc = {mm_reg[7:4] + 4'd1, 4'd0};
      else                     mm_inc = {mm_reg[7:4], mm_reg[3:0] + 4'd1};
    end
  end

  always_comb begin
    hh_inc = 8'h00;
    if (hh_reg != 8'h23) begin
      if (hh_reg[3:0] == 4'd9) hh_inc = {hh_reg[7:4] + 4'd1, 4'd0};
      else                     hh_inc = {hh_reg[7:4], hh_reg[3:0] + 4'd1};
    end
  end

  always_comb begin
    ss_next = ss_reg;
    mm_next = mm_reg;
    hh_next = hh_reg;
    if (set) begin
      if (load_ok) begin
        ss_next = s_ss;
        mm_next = s_mm;
        hh_next = s_hh;
      end
    end else if (tick) begin
      ss_next = ss_inc;
      if (sec_carry) mm_next = mm_inc;
      if (min_carry) hh_next = hh_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      ss_reg       <= 8'h00;
      mm_reg       <= 8'h00;
      hh_reg       <= 8'h00;
      sec_tick_reg <= 1'b0;
      min_tick_reg <= 1'b0;
      day_tick_reg <= 1'b0;
      set_err_reg  <= 1'b0;
    end else begin
      if (set)
        presc_reg <= '0;
      else if (ena)
        presc_reg <= (presc_reg == PRESC_MAX) ? '0 : presc_reg + DIV_W'(1);
      ss_reg       <= ss_next;
      mm_reg       <= mm_next;
      hh_reg       <= hh_next;
      sec_tick_reg <= tick;
      min_tick_reg <= sec_carry;
      day_tick_reg <= day_carry;
      set_err_reg  <= set && !load_ok;
    end
  end

`ifdef BCD_RTC_ALARM_EN
  logic alarm_reg;

  // Only a counted second may fire the alarm; a load landing on the alarm time stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alarm_reg <= 1'b0;
    else
      alarm_reg <= tick && al_en && (hh_next == al_hh) && (mm_next == al_mm) && (ss_next == 8'h00);
  end

  assign alarm = alarm_reg;
`endif

  always_comb begin
    case (hh_reg)
      8'h00:   hh12 = 8'h12;
      8'h13:   hh12 = 8'h01;
      8'h14:   hh12 = 8'h02;
      8'h15:   hh12 = 8'h03;
      8'h16:   hh12 = 8'h04;
      8'h17:   hh12 = 8'h05;
      8'h18:   hh12 = 8'h06;
      8'h19:   hh12 = 8'h07;
      8'h20:   hh12 = 8'h08;
      8'h21:   hh12 = 8'h09;
      8'h22:   hh12 = 8'h10;
      8'h23:   hh12 = 8'h11;
      default: hh12 = hh_reg;
    endcase
  end

  assign pm       = (hh_reg >= 8'h12);
  assign hh       = hh_reg;
  assign mm       = mm_reg;
  assign ss       = ss_reg;
  assign sec_tick = sec_tick_reg;
  assign min_tick = min_tick_reg;
  assign day_tick = day_tick_reg;
  assign set_err  = set_err_reg;

endmodule
